// File: rtl/store_checker_pkg.sv
// -----------------------------------------------------------------------------
// store_checker_pkg
// Shared definitions for the store-stream checker: FSM state encodings and the
// bit positions of the packed verdict vector. Benches import this package to
// decode state and verdicts without duplicating the encodings.
// -----------------------------------------------------------------------------
package store_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TMO  = 3'd4
  } sc_state_e;

  // Bit positions inside the 3-bit verdict vector {timeout, fail, pass}
  localparam int VB_PASS = 0;
  localparam int VB_FAIL = 1;
  localparam int VB_TMO  = 2;
  localparam int VB_W    = 3;

  // One-hot verdict implied by a state; non-terminal states give all zeros,
  // which keeps pass/fail/timeout mutually exclusive by construction.
  function automatic logic [VB_W-1:0] verdict_of(input sc_state_e st);
    logic [VB_W-1:0] v;
    v = 3'b000;
    case (st)
      ST_PASS: v[VB_PASS] = 1'b1;
      ST_FAIL: v[VB_FAIL] = 1'b1;
      ST_TMO:  v[VB_TMO]  = 1'b1;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/store_checker_table.sv
// -----------------------------------------------------------------------------
// store_checker_table
// DEPTH x (AW+DW) table of expected stores. One synchronous write port, one
// combinational read port. Asynchronous reset clears every entry.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   we, wr_idx          write strobe and entry index (idx >= DEPTH ignored)
//   wr_addr, wr_data    entry contents to write
//   rd_idx              read index (the checker's match pointer)
//   rd_addr, rd_data    entry at rd_idx, zero when rd_idx >= DEPTH
// -----------------------------------------------------------------------------
module store_checker_table #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int NUM_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic [NUM_W-1:0] rd_idx,
  output logic [AW-1:0]    rd_addr,
  output logic [DW-1:0]    rd_data
);

  logic [AW-1:0] addr_r [DEPTH];
  logic [DW-1:0] data_r [DEPTH];
  logic          wr_ok_s;

  // Only indices that address a real entry may be written
  always_comb begin
    wr_ok_s = 1'b0;
    if (we && ({1'b0, wr_idx} < (IDX_W + 1)'(DEPTH))) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Entry storage with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
      end
    end else if (wr_ok_s) begin
      addr_r[wr_idx] <= wr_addr;
      data_r[wr_idx] <= wr_data;
    end else begin
      addr_r <= addr_r;
      data_r <= data_r;
    end
  end

  // Combinational read; the pointer can step one past the last entry after
  // the final match, where zeros are returned instead of an out-of-range read
  always_comb begin
    rd_addr = '0;
    rd_data = '0;
    if (rd_idx < NUM_W'(DEPTH)) begin
      rd_addr = addr_r[rd_idx[IDX_W-1:0]];
      rd_data = data_r[rd_idx[IDX_W-1:0]];
    end else begin
      rd_addr = '0;
      rd_data = '0;
    end
  end

endmodule

// File: rtl/store_checker.sv
// -----------------------------------------------------------------------------
// store_checker
// Watches the core's data-memory write port and compares each store against an
// ordered table of expected (address, data) pairs. Stores inside an inclusive
// ignore window are tolerated; any other unexpected store is a fail. An
// optional RUN-cycle limit produces a timeout. Verdicts are sticky until the
// next start or reset.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cfg_we/cfg_idx/cfg_addr/cfg_data table programming (ignored in RUN)
//   cfg_num, ign_lo, ign_hi, tmo_limit  run configuration, latched on start
//   start                           start/restart pulse (ignored in RUN)
//   mem_we, mem_addr, mem_wdata     core store port
//   busy, pass, fail, timeout       status and sticky verdicts
//   match_cnt                       expected stores matched so far
//   err_addr, err_data              offending store captured on fail
// -----------------------------------------------------------------------------
module store_checker
  import store_checker_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int NUM_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [DW-1:0]    cfg_data,
  input  logic [NUM_W-1:0] cfg_num,
  input  logic [AW-1:0]    ign_lo,
  input  logic [AW-1:0]    ign_hi,
  input  logic [CNT_W-1:0] tmo_limit,
  input  logic             start,
  input  logic             mem_we,
  input  logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_wdata,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [NUM_W-1:0] match_cnt,
  output logic [AW-1:0]    err_addr,
  output logic [DW-1:0]    err_data
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sc_state_e        state_r;
  logic [NUM_W-1:0] num_r;
  logic [AW-1:0]    ign_lo_r;
  logic [AW-1:0]    ign_hi_r;
  logic [CNT_W-1:0] lim_r;
  logic [CNT_W-1:0] cnt_r;
  logic [NUM_W-1:0] ptr_r;
  logic [NUM_W-1:0] match_cnt_r;
  logic             busy_r;
  logic [VB_W-1:0]  verdict_r;
  logic [AW-1:0]    err_addr_r;
  logic [DW-1:0]    err_data_r;

  logic [AW-1:0]    exp_addr_s;
  logic [DW-1:0]    exp_data_s;
  logic             tbl_we_s;
  logic [NUM_W-1:0] num_eff_s;
  logic             match_s;
  logic             last_s;
  logic             fail_s;
  logic             tmo_s;

  // Table writes are frozen while a run is in progress
  always_comb begin
    tbl_we_s = 1'b0;
    if (state_r != ST_RUN) begin
      tbl_we_s = cfg_we;
    end else begin
      tbl_we_s = 1'b0;
    end
  end

  store_checker_table #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .NUM_W (NUM_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (tbl_we_s),
    .wr_idx  (cfg_idx),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_idx  (ptr_r),
    .rd_addr (exp_addr_s),
    .rd_data (exp_data_s)
  );

  // Store classification: ordered match first, then ignore window, else fail.
  // A count above DEPTH is clamped so the pointer never walks past the table.
  always_comb begin
    num_eff_s = cfg_num;
    if (cfg_num > NUM_W'(DEPTH)) begin
      num_eff_s = NUM_W'(DEPTH);
    end else begin
      num_eff_s = cfg_num;
    end
    match_s = mem_we && (mem_addr == exp_addr_s) && (mem_wdata == exp_data_s);
    last_s  = (ptr_r == (num_r - NUM_W'(1)));
    fail_s  = mem_we && !match_s &&
              !((mem_addr >= ign_lo_r) && (mem_addr <= ign_hi_r));
    // cnt_r holds the number of earlier RUN edges, so limit-1 marks the
    // limit-th RUN edge
    tmo_s   = (lim_r != '0) && (cnt_r == (lim_r - CNT_W'(1)));
  end

  // Checker FSM with registered status, verdicts and error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      num_r       <= '0;
      ign_lo_r    <= '0;
      ign_hi_r    <= '0;
      lim_r       <= '0;
      cnt_r       <= '0;
      ptr_r       <= '0;
      match_cnt_r <= '0;
      busy_r      <= 1'b0;
      verdict_r   <= 3'b000;
      err_addr_r  <= '0;
      err_data_r  <= '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
          if (match_s) begin
            ptr_r       <= ptr_r + NUM_W'(1);
            match_cnt_r <= match_cnt_r + NUM_W'(1);
          end else begin
            ptr_r       <= ptr_r;
            match_cnt_r <= match_cnt_r;
          end
          // Store outcome outranks the timeout on the same edge
          if (match_s && last_s) begin
            state_r   <= ST_PASS;
            busy_r    <= 1'b0;
            verdict_r <= verdict_of(ST_PASS);
          end else if (fail_s) begin
            state_r    <= ST_FAIL;
            busy_r     <= 1'b0;
            verdict_r  <= verdict_of(ST_FAIL);
            err_addr_r <= mem_addr;
            err_data_r <= mem_wdata;
          end else if (tmo_s) begin
            state_r   <= ST_TMO;
            busy_r    <= 1'b0;
            verdict_r <= verdict_of(ST_TMO);
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_IDLE, ST_PASS, ST_FAIL, ST_TMO: begin
          if (start) begin
            num_r       <= num_eff_s;
            ign_lo_r    <= ign_lo;
            ign_hi_r    <= ign_hi;
            lim_r       <= tmo_limit;
            cnt_r       <= '0;
            ptr_r       <= '0;
            match_cnt_r <= '0;
            err_addr_r  <= '0;
            err_data_r  <= '0;
            if (num_eff_s == '0) begin
              state_r   <= ST_PASS;
              busy_r    <= 1'b0;
              verdict_r <= verdict_of(ST_PASS);
            end else begin
              state_r   <= ST_RUN;
              busy_r    <= 1'b1;
              verdict_r <= 3'b000;
            end
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          verdict_r <= 3'b000;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign pass      = verdict_r[VB_PASS];
  assign fail      = verdict_r[VB_FAIL];
  assign timeout   = verdict_r[VB_TMO];
  assign match_cnt = match_cnt_r;
  assign err_addr  = err_addr_r;
  assign err_data  = err_data_r;

endmodule

// File: tb/tb_store_checker.sv
// -----------------------------------------------------------------------------
// tb_store_checker
// Directed bench for store_checker. Inputs change on the falling edge; outputs
// are sampled on the following falling edge, after the rising edge that acts
// on them. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_store_checker;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [1:0]    cfg_idx;
  logic [31:0]   cfg_addr;
  logic [31:0]   cfg_data;
  logic [2:0]    cfg_num;
  logic [31:0]   ign_lo;
  logic [31:0]   ign_hi;
  logic [15:0]   tmo_limit;
  logic          start;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          pass;
  logic          fail;
  logic          timeout;
  logic [2:0]    match_cnt;
  logic [31:0]   err_addr;
  logic [31:0]   err_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_checker #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_num   (cfg_num),
    .ign_lo    (ign_lo),
    .ign_hi    (ign_hi),
    .tmo_limit (tmo_limit),
    .start     (start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .pass      (pass),
    .fail      (fail),
    .timeout   (timeout),
    .match_cnt (match_cnt),
    .err_addr  (err_addr),
    .err_data  (err_data)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk_b({tag, ".busy"}, busy, 1'b0);
    chk_b({tag, ".pass"}, pass, 1'b0);
    chk_b({tag, ".fail"}, fail, 1'b0);
    chk_b({tag, ".timeout"}, timeout, 1'b0);
    chk_w({tag, ".match_cnt"}, 32'(match_cnt), 32'd0);
    chk_w({tag, ".err_addr"}, err_addr, 32'd0);
    chk_w({tag, ".err_data"}, err_data, 32'd0);
  endtask

  task automatic wr_entry(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] num, input logic [31:0] lo,
                          input logic [31:0] hi, input logic [15:0] lim);
    cfg_num   = num;
    ign_lo    = lo;
    ign_hi    = hi;
    tmo_limit = lim;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    tick();
    mem_we    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = 2'd0; cfg_addr = 32'd0; cfg_data = 32'd0;
    cfg_num = 3'd0; ign_lo = 32'd0; ign_hi = 32'd0; tmo_limit = 16'd0;
    start = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
    idle(2);
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_zero("post_reset");

    // Ignored store, then the one expected store
    wr_entry(2'd0, 32'd100, 32'd25);
    do_start(3'd1, 32'd96, 32'd96, 16'd500);
    chk_b("t1.busy_after_start", busy, 1'b1);
    store(32'd96, 32'd7);
    chk_b("t1.ignored_busy", busy, 1'b1);
    chk_b("t1.ignored_pass", pass, 1'b0);
    chk_b("t1.ignored_fail", fail, 1'b0);
    store(32'd100, 32'd25);
    chk_b("t1.pass", pass, 1'b1);
    chk_w("t1.match_cnt", 32'(match_cnt), 32'd1);
    chk_b("t1.busy", busy, 1'b0);
    chk_b("t1.fail", fail, 1'b0);

    // Wrong address outside the window, verdict sticky afterwards
    do_start(3'd1, 32'd96, 32'd96, 16'd500);
    chk_b("t2.pass_cleared", pass, 1'b0);
    store(32'd104, 32'd25);
    chk_b("t2.fail", fail, 1'b1);
    chk_w("t2.err_addr", err_addr, 32'd104);
    chk_w("t2.err_data", err_data, 32'd25);
    chk_b("t2.busy", busy, 1'b0);
    store(32'd100, 32'd25);
    chk_b("t2.sticky_fail", fail, 1'b1);
    chk_b("t2.sticky_pass", pass, 1'b0);
    chk_w("t2.sticky_match", 32'(match_cnt), 32'd0);

    // Ordering: second entry presented first fails; restart then in order
    wr_entry(2'd0, 32'd0, 32'd1);
    wr_entry(2'd1, 32'd4, 32'd2);
    do_start(3'd2, 32'd1, 32'd0, 16'd500);
    store(32'd4, 32'd2);
    chk_b("t3.early_fail", fail, 1'b1);
    chk_w("t3.err_addr", err_addr, 32'd4);
    do_start(3'd2, 32'd1, 32'd0, 16'd500);
    chk_b("t3.restart_fail_clr", fail, 1'b0);
    chk_w("t3.restart_err_clr", err_addr, 32'd0);
    chk_b("t3.restart_busy", busy, 1'b1);
    store(32'd0, 32'd1);
    chk_w("t3.match1", 32'(match_cnt), 32'd1);
    chk_b("t3.mid_pass", pass, 1'b0);
    store(32'd4, 32'd2);
    chk_b("t3.pass", pass, 1'b1);
    chk_w("t3.match2", 32'(match_cnt), 32'd2);

    // Timeout after exactly 20 RUN edges
    do_start(3'd1, 32'd1, 32'd0, 16'd20);
    idle(19);
    chk_b("t4.edge19_tmo", timeout, 1'b0);
    chk_b("t4.edge19_busy", busy, 1'b1);
    tick();
    chk_b("t4.edge20_tmo", timeout, 1'b1);
    chk_b("t4.edge20_busy", busy, 1'b0);

    // Limit 0 never times out; a stray store then ends the run
    do_start(3'd1, 32'd1, 32'd0, 16'd0);
    idle(1000);
    chk_b("t4.nolimit_busy", busy, 1'b1);
    chk_b("t4.nolimit_tmo", timeout, 1'b0);
    store(32'd8, 32'd8);
    chk_b("t4.stray_fail", fail, 1'b1);

    // Final match on the limit edge wins; table write during RUN is dropped
    wr_entry(2'd0, 32'd100, 32'd25);
    do_start(3'd1, 32'd1, 32'd0, 16'd10);
    idle(4);
    wr_entry(2'd0, 32'd200, 32'd99);
    idle(4);
    chk_b("t5.edge9_busy", busy, 1'b1);
    chk_b("t5.edge9_tmo", timeout, 1'b0);
    store(32'd100, 32'd25);
    chk_b("t5.pass", pass, 1'b1);
    chk_b("t5.tmo", timeout, 1'b0);
    chk_w("t5.match_cnt", 32'(match_cnt), 32'd1);

    // Zero expected stores passes immediately
    do_start(3'd0, 32'd1, 32'd0, 16'd0);
    chk_b("t6.num0_pass", pass, 1'b1);
    chk_b("t6.num0_busy", busy, 1'b0);

    // Reset mid-run clears outputs and the table
    do_start(3'd2, 32'd1, 32'd0, 16'd0);
    store(32'd100, 32'd25);
    chk_w("t7.match_before_rst", 32'(match_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("t7.async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk_zero("t7.after_rst");
    do_start(3'd1, 32'd1, 32'd0, 16'd0);
    chk_b("t7.restart_busy", busy, 1'b1);
    store(32'd0, 32'd0);
    chk_b("t7.cleared_table_pass", pass, 1'b1);
    chk_b("t7.cleared_table_fail", fail, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
